branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
Parametrised branch predictor that removes the fixed branch penalty of the 5-stage pipeline. Each entry holds a branch target (BTB) and a saturating direction counter.
- IF stage looks it up combinationally with the fetch PC to choose the next PC.
- MEM stage, where branches and jumps resolve, trains it one update per cycle.
- Successor to the always-not-taken, flush-on-branch scheme: generalised in entry count, counter width and XLEN.

Parameters:
ENTRIES, 16, number of direct-mapped entries; power of two, >= 2
XLEN, 32, PC / target width
CNT_W, 2, direction counter width; >= 1
(derived, not overridable) IDX_W = log2(ENTRIES); TAG_W = XLEN - IDX_W - 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
if_pc  in  XLEN  fetch PC for lookup
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  XLEN  predicted next PC
upd_valid  in  1  resolved control-transfer instruction in MEM this cycle
upd_pc  in  XLEN  PC of the resolved instruction
upd_taken  in  1  actual direction
upd_uncond  in  1  JAL/JALR (always taken)
upd_target  in  XLEN  actual target
upd_mispred  in  1  prediction carried down the pipe was wrong
bp_clear  in  1  synchronous invalidate of all entries
perf_mispred  out  32  count of mispredicted updates

Behaviour:
- Index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Lookup, purely combinational from registered state, zero latency:
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && cnt[idx][CNT_W-1].
  - pred_target = pred_taken ? target[idx] : if_pc + 4, truncated to XLEN (wraps).
- Update on rising edge when upd_valid=1:
  - Hit, taken: counter saturating +1 (stays at 2^CNT_W-1); target <= upd_target.
  - Hit, not taken: counter saturating -1 (stays at 0); target unchanged; entry stays valid.
  - Miss, taken: allocate (overwrite any occupant); valid <= 1; tag/target written; counter <= 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no state change.
  - upd_uncond=1: treated as taken; counter forced to 2^CNT_W-1 on hit or allocate.
- bp_clear=1: all valid bits cleared at next edge. Has priority over a same-cycle update, which is discarded. Counters and targets are retained but unreachable.
- perf_mispred: +1 per edge with upd_valid && upd_mispred; saturates at 0xFFFFFFFF; not affected by bp_clear.
- Same-index update and lookup in one cycle: lookup returns pre-update state (see BP_BYPASS_EN).
- Reset (rst=0, asynchronous, effective mid-cycle and mid-operation):
  - All valid=0; counters=2^(CNT_W-1)-1 (weakly not taken); targets=0; perf_mispred=0.
  - Hence pred_hit=0, pred_taken=0, pred_target=if_pc+4 while rst=0 and after release.
- CNT_W=1: counter is a single taken bit; allocate value is 1.

Optional Feature:
Macro BP_BYPASS_EN.
- Defined: when upd_valid=1 and upd_pc index/tag equal if_pc index/tag in the same cycle, lookup outputs reflect the post-update entry state (as if written already). bp_clear in the same cycle forces pred_hit=0.
- Undefined: lookup always sees registered state; update visible from the next cycle.

Test Plan:
- Reset then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_target=0x104; perf_mispred=0.
- Update pc=0x100, taken, target=0x200 (cond); next cycle if_pc=0x100 -> hit=1, taken=1 (cnt=2), target=0x200. Two not-taken updates -> cnt=0, taken=0, target=0x104; hit still 1.
- ENTRIES=16: allocate 0x100 then taken update 0x140 (same index, different tag) -> lookup 0x100 hit=0, target 0x104; lookup 0x140 hit=1.
- upd_uncond=1 pc=0x80 target=0x10 -> counter=3; one not-taken update -> cnt=2, still predicted taken to 0x10.
- bp_clear and taken update asserted the same cycle -> next cycle every lookup hit=0, update discarded. Five upd_mispred updates -> perf_mispred=5; assert rst low mid-cycle -> outputs clear immediately.
- With BP_BYPASS_EN: if_pc=upd_pc=0x300, taken, target=0x400 in the same cycle -> pred_taken=1, pred_target=0x400 that cycle. Without the macro -> 0x304 that cycle, 0x400 next.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; combinational IF lookup, MEM-stage training.
// Optional macro BP_BYPASS_EN: same-cycle update to the looked-up entry is forwarded to the lookup outputs.
module branch_predictor #(
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_uncond,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispred,
    input  logic            bp_clear,
    output logic [31:0]     perf_mispred
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_W'(1);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [XLEN-1:0]    tgt_q [ENTRIES];

    logic [IDX_W-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0] if_tag, upd_tag;
    logic             unused_pc_bits;

    assign if_idx  = if_pc[IDX_W+1:2];
    assign if_tag  = if_pc[XLEN-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_W+2];
    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    logic             upd_hit, upd_is_taken, upd_write;
    logic [CNT_W-1:0] upd_cnt_cur, new_cnt;
    logic [XLEN-1:0]  new_tgt;

    assign upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign upd_is_taken = upd_taken | upd_uncond;
    // A miss that resolves not-taken leaves the table untouched.
    assign upd_write    = upd_valid && (upd_hit || upd_is_taken);
    assign upd_cnt_cur  = cnt_q[upd_idx];

    always_comb begin
        new_cnt = upd_cnt_cur;
        if (upd_uncond) begin
            new_cnt = CNT_MAX;
        end else if (!upd_hit) begin
            new_cnt = CNT_WT;
        end else if (upd_taken) begin
            if (upd_cnt_cur != CNT_MAX) new_cnt = upd_cnt_cur + CNT_W'(1);
        end else begin
            if (upd_cnt_cur != '0) new_cnt = upd_cnt_cur - CNT_W'(1);
        end
    end

    assign new_tgt = upd_is_taken ? upd_target : tgt_q[upd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= CNT_WNT;
                tgt_q[i] <= '0;
            end
        end else if (bp_clear) begin
            valid_q <= '0;
        end else if (upd_write) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            cnt_q[upd_idx]   <= new_cnt;
            tgt_q[upd_idx]   <= new_tgt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_mispred <= '0;
        end else if (upd_valid && upd_mispred && (perf_mispred != '1)) begin
            perf_mispred <= perf_mispred + 32'd1;
        end
    end

    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag;
    logic [CNT_W-1:0] lk_cnt;
    logic [XLEN-1:0]  lk_tgt;

    always_comb begin
        lk_valid = valid_q[if_idx];
        lk_tag   = tag_q[if_idx];
        lk_cnt   = cnt_q[if_idx];
        lk_tgt   = tgt_q[if_idx];
`ifdef BP_BYPASS_EN
        if (upd_write && (upd_idx == if_idx) && (upd_tag == if_tag)) begin
            lk_valid = 1'b1;
            lk_tag   = upd_tag;
            lk_cnt   = new_cnt;
            lk_tgt   = new_tgt;
        end
        if (bp_clear) lk_valid = 1'b0;
`endif
    end

    assign pred_hit    = lk_valid && (lk_tag == if_tag);
    assign pred_taken  = pred_hit && lk_cnt[CNT_W-1];
    assign pred_target = pred_taken ? lk_tgt : (if_pc + XLEN'(4));

endmodule
